// File: rtl/adc_stream_sink.sv
// adc_stream_sink
// Avalon-ST sink for the ADC sequencer response stream. Captures one channel,
// converts 12-bit offset-binary samples to 16-bit signed audio, and buffers them
// in a small FIFO with a valid/ready output. Reports FIFO overflow and packet
// framing errors.
// Optional build macro: ADC_SINK_AVG_EN -- averages every 4 matching samples
// into one output sample before the FIFO.
module adc_stream_sink #(
  parameter int CHANNEL    = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          adc_response_valid,
  input  logic                          adc_response_startofpacket,
  input  logic                          adc_response_endofpacket,
  input  logic                          adc_response_empty,
  input  logic [4:0]                    adc_response_channel,
  input  logic [11:0]                   adc_response_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [15:0]                   sample_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              overflow_count,
  output logic                          framing_error,
  input  logic                          clear_status
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]    CH_L    = 5'(CHANNEL);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  // Offset-binary to signed: subtracting 2048 flips the MSB; then scale by 16.
  function automatic logic [15:0] to_audio(input logic [11:0] d);
    return {~d[11], d[10:0], 4'b0000};
  endfunction

  // ---------------------------------------------------------------------------
  // Beat qualification. The empty field carries no information for
  // single-symbol beats; it is folded in as a no-op so the port stays connected.
  // ---------------------------------------------------------------------------
  logic beat_valid_s;
  logic match_s;

  assign beat_valid_s = adc_response_valid & (adc_response_empty | 1'b1);
  assign match_s      = beat_valid_s & (adc_response_channel == CH_L);

  // ---------------------------------------------------------------------------
  // Stage 1: conversion register (optionally with 4-sample averaging)
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_data_q,  s1_data_d;

`ifdef ADC_SINK_AVG_EN
  logic [13:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [13:0] acc_sum_s;

  // Accumulate four matching samples and emit their mean on the fourth.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_sum_s  = acc_q + {2'b00, adc_response_data};
    if (match_s) begin
      if (cnt_q == 2'd3) begin
        s1_valid_d = 1'b1;
        s1_data_d  = to_audio(acc_sum_s[13:2]);
        acc_d      = 14'd0;
        cnt_d      = 2'd0;
      end else begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Accumulator state; reset drops any partial average.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      acc_q <= 14'd0;
      cnt_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  // Convert every matching sample individually.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    if (match_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = to_audio(adc_response_data);
    end else begin
      s1_valid_d = 1'b0;
    end
  end
`endif

  // Stage-1 register; its valid bit is a one-cycle push request.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 16'h0000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          sample_valid_q, sample_valid_d;
  logic [15:0]   sample_data_q,  sample_data_d;
  logic          push_s, pop_s, full_s, push_ok_s, drop_s;

  // Push/pop arbitration, pointer and level update, next head selection.
  always_comb begin
    push_s    = s1_valid_q;
    pop_s     = sample_valid_q & sample_ready;
    full_s    = (level_q == DEPTH_L);
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = s1_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    sample_valid_d = (level_d != {(AW+1){1'b0}});
    if (sample_valid_d) begin
      sample_data_d = mem_d[rd_ptr_d];
    end else begin
      sample_data_d = 16'h0000;
    end
  end

  // FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      level_q        <= {(AW+1){1'b0}};
      sample_valid_q <= 1'b0;
      sample_data_q  <= 16'h0000;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM and status
  // ---------------------------------------------------------------------------
  frame_state_e     state_q, state_d;
  logic             frame_err_s;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  // Framing next-state on every valid beat regardless of channel.
  always_comb begin
    state_d     = state_q;
    frame_err_s = 1'b0;
    if (beat_valid_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!adc_response_startofpacket) begin
            frame_err_s = 1'b1;
            state_d     = ST_IDLE;
          end else if (adc_response_endofpacket) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IN_PKT;
          end
        end
        ST_IN_PKT: begin
          if (adc_response_startofpacket) begin
            frame_err_s = 1'b1;
            state_d     = adc_response_endofpacket ? ST_IDLE : ST_IN_PKT;
          end else if (adc_response_endofpacket) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IN_PKT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Framing state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status update: clear has priority over any event in the same cycle.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (clear_status) begin
      ovf_d  = {CNT_W{1'b0}};
      ferr_d = 1'b0;
    end else begin
      if (drop_s && (ovf_q != {CNT_W{1'b1}})) begin
        ovf_d = ovf_q + 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (frame_err_s) begin
        ferr_d = 1'b1;
      end else begin
        ferr_d = ferr_q;
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ovf_q  <= {CNT_W{1'b0}};
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  assign sample_valid   = sample_valid_q;
  assign sample_data    = sample_data_q;
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign framing_error  = ferr_q;

endmodule

// File: tb/tb_adc_stream_sink.sv
// Directed self-checking bench for adc_stream_sink (CHANNEL=1, FIFO_DEPTH=8).
module tb_adc_stream_sink;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        adc_response_valid;
  logic        adc_response_startofpacket;
  logic        adc_response_endofpacket;
  logic        adc_response_empty;
  logic [4:0]  adc_response_channel;
  logic [11:0] adc_response_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_data;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_count;
  logic        framing_error;
  logic        clear_status;

  int n_checks = 0;
  int n_fail   = 0;

  adc_stream_sink #(.CHANNEL(1), .FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk_clk                    (clk_clk),
    .reset_reset                (reset_reset),
    .adc_response_valid         (adc_response_valid),
    .adc_response_startofpacket (adc_response_startofpacket),
    .adc_response_endofpacket   (adc_response_endofpacket),
    .adc_response_empty         (adc_response_empty),
    .adc_response_channel       (adc_response_channel),
    .adc_response_data          (adc_response_data),
    .sample_valid               (sample_valid),
    .sample_ready               (sample_ready),
    .sample_data                (sample_data),
    .fifo_level                 (fifo_level),
    .overflow_count             (overflow_count),
    .framing_error              (framing_error),
    .clear_status               (clear_status)
  );

  always #5 clk_clk = ~clk_clk;

  // Reference conversion: (data - 2048) * 16 as a 16-bit two's-complement value.
  function automatic logic [15:0] exp_conv(input logic [11:0] d);
    int v;
    v = (int'(d) - 2048) * 16;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [4:0] ch, input logic [11:0] d);
    adc_response_valid         = 1'b1;
    adc_response_startofpacket = sop;
    adc_response_endofpacket   = eop;
    adc_response_channel       = ch;
    adc_response_data          = d;
  endtask

  task automatic idle();
    adc_response_valid         = 1'b0;
    adc_response_startofpacket = 1'b0;
    adc_response_endofpacket   = 1'b0;
    adc_response_channel       = 5'd0;
    adc_response_data          = 12'h000;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    beat(1'b1, 1'b1, 5'd1, 12'h555);
    tick(); tick();
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_checks++; if (sample_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", sample_data); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", framing_error); end
    idle();
    reset_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sample_ready = 1'b1;
    beat(1'b1, 1'b0, 5'd1, 12'h000); tick();
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 got %b want 0", sample_valid); end
    beat(1'b0, 1'b0, 5'd1, 12'h800); tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 16'h8000) begin n_fail++; $display("FAIL basic_s0 got v=%b d=%h want v=1 d=8000", sample_valid, sample_data); end
    beat(1'b0, 1'b1, 5'd1, 12'hFFF); tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 16'h0000) begin n_fail++; $display("FAIL basic_s1 got v=%b d=%h want v=1 d=0000", sample_valid, sample_data); end
    idle(); tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 16'h7FF0) begin n_fail++; $display("FAIL basic_s2 got v=%b d=%h want v=1 d=7ff0", sample_valid, sample_data); end
    tick();
    n_checks++; if (sample_valid !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL basic_empty got v=%b lvl=%0d want v=0 lvl=0", sample_valid, fifo_level); end
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL basic_ferr got %b want 0", framing_error); end
  endtask

  task automatic test_other_channel();
    sample_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b1, 5'd2, 12'h100 + 12'(i)); tick();
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL other_ch_lvl%0d got %0d want 0", i, fifo_level); end
    end
    idle(); tick(); tick();
    n_checks++; if (fifo_level !== 4'd0 || sample_valid !== 1'b0) begin n_fail++; $display("FAIL other_ch_end got lvl=%0d v=%b want 0 0", fifo_level, sample_valid); end
  endtask

  task automatic test_overflow();
    logic [11:0] d;
    sample_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 12'(i * 12'h111);
      beat(1'b1, 1'b1, 5'd1, d); tick();
    end
    idle(); tick(); tick();
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
    n_checks++; if (overflow_count !== 16'd2) begin n_fail++; $display("FAIL ovf_count got %0d want 2", overflow_count); end
    sample_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 12'(i * 12'h111);
      n_checks++; if (sample_valid !== 1'b1 || sample_data !== exp_conv(d)) begin n_fail++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, sample_valid, sample_data, exp_conv(d)); end
      tick();
    end
    n_checks++; if (sample_valid !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL ovf_drained got v=%b lvl=%0d want 0 0", sample_valid, fifo_level); end
    sample_ready = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [11:0] d;
    sample_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 12'h0A0 + 12'(i);
      beat(1'b1, 1'b1, 5'd1, d); tick();
    end
    idle(); tick(); tick();
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_fill got %0d want 8", fifo_level); end
    beat(1'b1, 1'b1, 5'd1, 12'h123); tick();
    idle(); sample_ready = 1'b1; tick();
    sample_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_simul_lvl got %0d want 8", fifo_level); end
    n_checks++; if (overflow_count !== 16'd2) begin n_fail++; $display("FAIL full_simul_ovf got %0d want 2", overflow_count); end
    sample_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      d = (i == 8) ? 12'h123 : 12'h0A0 + 12'(i);
      n_checks++; if (sample_valid !== 1'b1 || sample_data !== exp_conv(d)) begin n_fail++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, sample_valid, sample_data, exp_conv(d)); end
      tick();
    end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL full_empty got %0d want 0", fifo_level); end
  endtask

  task automatic test_framing();
    sample_ready = 1'b1;
    beat(1'b0, 1'b0, 5'd1, 12'hC00); tick();
    n_checks++; if (framing_error !== 1'b1) begin n_fail++; $display("FAIL ferr_nosop got %b want 1", framing_error); end
    idle(); tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 16'h4000) begin n_fail++; $display("FAIL ferr_capture got v=%b d=%h want v=1 d=4000", sample_valid, sample_data); end
    tick();
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL clear_ferr got %b want 0", framing_error); end
    n_checks++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL clear_ovf got %0d want 0", overflow_count); end
    beat(1'b0, 1'b0, 5'd3, 12'h000); clear_status = 1'b1; tick();
    clear_status = 1'b0; idle();
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL clear_wins got %b want 0", framing_error); end
    tick();
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL clear_wins_hold got %b want 0", framing_error); end
    beat(1'b0, 1'b0, 5'd3, 12'h000); tick();
    n_checks++; if (framing_error !== 1'b1) begin n_fail++; $display("FAIL ferr_after_clear got %b want 1", framing_error); end
    idle(); clear_status = 1'b1; tick(); clear_status = 1'b0;
    beat(1'b1, 1'b0, 5'd3, 12'h000); tick();
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL ferr_good_sop got %b want 0", framing_error); end
    beat(1'b1, 1'b0, 5'd3, 12'h000); tick();
    n_checks++; if (framing_error !== 1'b1) begin n_fail++; $display("FAIL ferr_dup_sop got %b want 1", framing_error); end
    beat(1'b0, 1'b1, 5'd3, 12'h000); tick();
    idle(); clear_status = 1'b1; tick(); clear_status = 1'b0;
    beat(1'b1, 1'b1, 5'd3, 12'h000); tick();
    beat(1'b0, 1'b0, 5'd3, 12'h000); adc_response_valid = 1'b0; tick();
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL ferr_single_beat got %b want 0", framing_error); end
    idle(); tick(); tick();
  endtask

  task automatic test_reset_midstream();
    sample_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b1, 5'd1, 12'h700 + 12'(i)); tick();
    end
    idle();
    n_checks++; if (fifo_level !== 4'd2) begin n_fail++; $display("FAIL mid_pre_level got %0d want 2", fifo_level); end
    reset_reset = 1'b1; tick(); reset_reset = 1'b0;
    n_checks++; if (fifo_level !== 4'd0 || sample_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got lvl=%0d v=%b want 0 0", fifo_level, sample_valid); end
    tick(); tick();
    n_checks++; if (fifo_level !== 4'd0 || sample_data !== 16'h0000) begin n_fail++; $display("FAIL mid_inflight got lvl=%0d d=%h want 0 0000", fifo_level, sample_data); end
  endtask

  task automatic test_avg();
    sample_ready = 1'b0;
    beat(1'b1, 1'b0, 5'd1, 12'h800); tick();
    beat(1'b0, 1'b0, 5'd1, 12'h804); tick();
    beat(1'b0, 1'b0, 5'd1, 12'h808); tick();
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL avg_partial got %0d want 0", fifo_level); end
    beat(1'b0, 1'b1, 5'd1, 12'h80C); tick();
    idle();
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL avg_lat1 got %0d want 0", fifo_level); end
    tick();
    n_checks++; if (fifo_level !== 4'd1 || sample_data !== 16'h0060) begin n_fail++; $display("FAIL avg_push got lvl=%0d d=%h want 1 0060", fifo_level, sample_data); end
    tick(); tick();
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL avg_single got %0d want 1", fifo_level); end
  endtask

  initial begin
    reset_reset  = 1'b1;
    sample_ready = 1'b0;
    clear_status = 1'b0;
    adc_response_empty = 1'b0;
    idle();
    test_reset();
`ifdef ADC_SINK_AVG_EN
    test_avg();
`else
    test_basic();
    test_other_channel();
    test_overflow();
    test_full_simul();
    test_framing();
    test_reset_midstream();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_stream_sink.md
Name: adc_stream_sink

Overview:
- Avalon-ST sink for the ADC sequencer response stream (valid / startofpacket / endofpacket / empty / channel / data, no backpressure).
- Selects one ADC channel and converts each 12-bit offset-binary sample to 16-bit signed audio.
- Buffers converted samples in a small FIFO that feeds the effects chain over a valid/ready handshake.
- Reports overflow and packet-framing errors for debug.

Parameters:
- CHANNEL, 1, ADC channel number captured; beats on other channels are discarded.
- FIFO_DEPTH, 8, output FIFO depth in entries; must be a power of 2, at least 2.
- CNT_W, 16, width of the saturating overflow counter.

Ports:
- clk_clk  in  1  single system clock; all logic is on its rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- adc_response_valid  in  1  response beat is present this cycle.
- adc_response_startofpacket  in  1  first beat of a sequence.
- adc_response_endofpacket  in  1  last beat of a sequence.
- adc_response_empty  in  1  ignored.
- adc_response_channel  in  5  channel of the beat.
- adc_response_data  in  12  unsigned offset-binary sample.
- sample_valid  out  1  FIFO head is valid.
- sample_ready  in  1  downstream accepts the head.
- sample_data  out  16  signed sample at the FIFO head.
- fifo_level  out  log2(FIFO_DEPTH)+1  current number of stored entries.
- overflow_count  out  CNT_W  samples dropped because the FIFO was full; saturates at all-ones.
- framing_error  out  1  sticky framing-violation flag.
- clear_status  in  1  synchronous clear of overflow_count and framing_error.

Behaviour:
- Reset, and any cycle with reset_reset high:
  - sample_valid=0, sample_data=0, fifo_level=0, overflow_count=0, framing_error=0.
  - FIFO pointers and the stage-1 register cleared; FSM goes to IDLE.
  - Reset mid-stream discards all buffered and in-flight samples.
- Input acceptance:
  - The sink has no ready output; every beat with valid=1 is consumed in that cycle.
  - A beat "matches" when valid=1 and channel==CHANNEL.
- Stage 1 (registered): a matching beat at edge N loads conv = ({1'b0,data} - 2048) shifted left by 4, as a signed 16-bit value.
  - 0x000 -> 0x8000; 0x800 -> 0x0000; 0xFFF -> 0x7FF0.
  - A stage-1 valid bit is set for one cycle.
- Stage 2 (FIFO push) at edge N+1:
  - The entry becomes visible on sample_valid/sample_data after edge N+1.
  - Latency from input beat to sample_valid is 2 cycles when the FIFO was empty.
- Pop: sample_valid & sample_ready at an edge removes the head. sample_data holds stable while sample_valid=1 and sample_ready=0.
- Full handling:
  - Push with fifo_level==FIFO_DEPTH and no pop in the same cycle: sample is dropped and overflow_count increments (saturating).
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
  - Push and pop in the same cycle while empty: no bypass; the pop is not possible because sample_valid=0, so only the push takes effect.
- Pointers wrap modulo FIFO_DEPTH. fifo_level tracks push minus pop exactly.
- Framing FSM (evaluates every valid beat, on any channel):
  - IDLE:
    - sop & !eop -> IN_PKT.
    - sop & eop -> IDLE (single-beat packet).
    - !sop -> set framing_error, stay IDLE.
  - IN_PKT:
    - eop & !sop -> IDLE.
    - sop (duplicate start) -> set framing_error; go to IDLE if eop, else stay IN_PKT.
    - neither -> stay IN_PKT.
- Framing errors do not block capture; samples are still converted and stored.
- clear_status clears both status outputs. If an event occurs in the same cycle, clear wins, then the event is counted from the next cycle.

Optional Feature:
- Macro: ADC_SINK_AVG_EN.
- Defined:
  - Stage 1 accumulates 4 consecutive matching samples in a 14-bit unsigned sum.
  - On the 4th sample, (sum >> 2) is converted as above and pushed; the accumulator and count then clear.
  - Output rate is 1/4 of the matching input rate; latency is 2 cycles from the 4th beat.
  - Reset clears a partial accumulation.
- Undefined: every matching sample is pushed individually, as described in Behaviour.

Test Plan:
- Reset, then 3-beat packet on channel CHANNEL with data 0x000, 0x800, 0xFFF and sample_ready=1 -> sample_data 0x8000, 0x0000, 0x7FF0 in order; each sample_valid appears 2 cycles after its beat; framing_error=0.
- Beats on channel 2 with CHANNEL=1 -> no push, fifo_level stays 0.
- sample_ready=0, 10 matching beats (FIFO_DEPTH=8) -> fifo_level=8, overflow_count=2; then raise sample_ready -> the first 8 samples drain in order.
- FIFO full plus simultaneous matching beat and pop -> fifo_level stays 8, overflow_count unchanged.
- Beat without sop in IDLE -> framing_error=1; a later pulse on clear_status -> framing_error=0 and overflow_count=0.
- With ADC_SINK_AVG_EN, inputs 0x800, 0x804, 0x808, 0x80C -> a single push of 0x0060.
